// File: rtl/serial_sub16.sv
// rtl/serial_sub16.sv - bit-serial unsigned subtractor, LSB first, one bit per clock.
// Optional n/z/p condition outputs when SERIAL_SUB_NZP_EN is defined.
module serial_sub16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             borrow
`ifdef SERIAL_SUB_NZP_EN
  ,
  output logic             n,
  output logic             z,
  output logic             p
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             borrow_q, borrow_d;
  logic             diff_bit, br_next;
  logic [WIDTH-1:0] final_res;

  // One full-subtractor slice on the current LSBs.
  assign diff_bit  = a_q[0] ^ b_q[0] ^ br_q;
  assign br_next   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  assign final_res = {diff_bit, res_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    borrow_d = borrow_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = in1;
          b_d     = in2;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = final_res;
        br_d  = br_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          out_d    = final_res;
          borrow_d = br_next;
          cnt_d    = '0;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      out_q    <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      borrow_q <= borrow_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign out    = out_q;
  assign borrow = borrow_q;

`ifdef SERIAL_SUB_NZP_EN
  logic n_q, z_q, p_q;
  logic load_nzp;

  assign load_nzp = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_q <= 1'b0;
      z_q <= 1'b0;
      p_q <= 1'b0;
    end else if (load_nzp) begin
      n_q <= final_res[WIDTH-1];
      z_q <= (final_res == '0);
      p_q <= ~final_res[WIDTH-1] & (final_res != '0);
    end
  end

  assign n = n_q;
  assign z = z_q;
  assign p = p_q;
`endif

endmodule

// File: tb/tb_serial_sub16.sv
// tb/tb_serial_sub16.sv - directed self-checking bench for serial_sub16 (WIDTH=16).
module tb_serial_sub16;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] in1;
  logic [15:0] in2;
  logic        busy;
  logic        done;
  logic [15:0] out;
  logic        borrow;
`ifdef SERIAL_SUB_NZP_EN
  logic        n, z, p;
`endif

  int errors = 0;
  int checks = 0;
  logic [15:0] last_out;

  serial_sub16 #(.WIDTH(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .in1    (in1),
    .in2    (in2),
    .busy   (busy),
    .done   (done),
    .out    (out),
    .borrow (borrow)
`ifdef SERIAL_SUB_NZP_EN
    ,
    .n      (n),
    .z      (z),
    .p      (p)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_nzp(input string tag, input logic [15:0] res);
`ifdef SERIAL_SUB_NZP_EN
    check({tag, ".n"}, {31'd0, n}, {31'd0, res[15]});
    check({tag, ".z"}, {31'd0, z}, {31'd0, (res == 16'h0)});
    check({tag, ".p"}, {31'd0, p}, {31'd0, (!res[15] && res != 16'h0)});
`else
    if (tag.len() < 0) $display("%s %0h", tag, res);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept at edge k; done must appear after edge k+16, not k+15.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eo, input logic eb);
    in1 = a; in2 = b; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, ".busy0"}, {31'd0, busy}, 32'd1);
    check({tag, ".hold"}, {16'd0, out}, {16'd0, last_out});
    repeat (15) tick();
    check({tag, ".early"}, {30'd0, busy, done}, 32'd2);
    tick();
    check({tag, ".done"}, {30'd0, busy, done}, 32'd1);
    check({tag, ".out"}, {16'd0, out}, {16'd0, eo});
    check({tag, ".borrow"}, {31'd0, borrow}, {31'd0, eb});
    check_nzp(tag, eo);
    tick();
    check({tag, ".idle"}, {30'd0, busy, done}, 32'd0);
    last_out = eo;
  endtask

  initial begin
    int done_seen;
    reset = 1'b1; start = 1'b0; in1 = '0; in2 = '0;
    last_out = 16'h0;
    #1;
    check("rst.async", {30'd0, busy, done}, 32'd0);
    tick(); tick();
    check("rst.out", {16'd0, out}, 32'd0);
    check("rst.borrow", {31'd0, borrow}, 32'd0);
    reset = 1'b0;

    run_op("op5m3", 16'h0005, 16'h0003, 16'h0002, 1'b0);
    run_op("op3m5", 16'h0003, 16'h0005, 16'hFFFE, 1'b1);
    run_op("op8000m1", 16'h8000, 16'h0001, 16'h7FFF, 1'b0);
    run_op("opeq", 16'h1234, 16'h1234, 16'h0000, 1'b0);
    run_op("op0mffff", 16'h0000, 16'hFFFF, 16'h0001, 1'b1);

    // Back-to-back: start held high, B captured in A's DONE cycle.
    in1 = 16'h00F0; in2 = 16'h000F; start = 1'b1;
    tick();
    in1 = 16'h0001; in2 = 16'h0002;
    repeat (16) tick();
    check("b2b.a.done", {30'd0, busy, done}, 32'd1);
    check("b2b.a.out", {16'd0, out}, 32'h00E1);
    check("b2b.a.borrow", {31'd0, borrow}, 32'd0);
    tick();
    start = 1'b0;
    check("b2b.b.accept", {30'd0, busy, done}, 32'd2);
    check("b2b.b.hold", {16'd0, out}, 32'h00E1);
    repeat (16) tick();
    check("b2b.b.done", {30'd0, busy, done}, 32'd1);
    check("b2b.b.out", {16'd0, out}, 32'hFFFF);
    check("b2b.b.borrow", {31'd0, borrow}, 32'd1);
    tick();
    check("b2b.idle", {30'd0, busy, done}, 32'd0);
    last_out = 16'hFFFF;

    // Start pulse and operand changes mid-RUN are ignored.
    in1 = 16'h0100; in2 = 16'h0001; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    start = 1'b1; in1 = 16'hAAAA; in2 = 16'h5555;
    tick();
    start = 1'b0;
    check("mid.busy", {30'd0, busy, done}, 32'd2);
    repeat (7) tick();
    check("mid.done", {30'd0, busy, done}, 32'd1);
    check("mid.out", {16'd0, out}, 32'h00FF);
    check("mid.borrow", {31'd0, borrow}, 32'd0);
    tick();
    check("mid.idle", {30'd0, busy, done}, 32'd0);

    // Asynchronous reset mid-RUN aborts the op.
    in1 = 16'h0009; in2 = 16'h0004; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    #2 reset = 1'b1;
    #1;
    check("arst.busy", {30'd0, busy, done}, 32'd0);
    check("arst.out", {16'd0, out}, 32'd0);
    check("arst.borrow", {31'd0, borrow}, 32'd0);
    tick();
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) done_seen++;
    end
    check("arst.nodone", done_seen, 32'd0);
    last_out = 16'h0000;
    run_op("post_rst", 16'h0009, 16'h0004, 16'h0005, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
